alu_req_sequencer: RTL and testbench

//  Shares one 8-bit signed ALU between two requesters. Arbitrates round-robin, holds the
//  ALU operands stable for ALU_LAT cycles and captures f/ovf/take_branch. Returns the

---
 rtl/alu_req_sequencer.sv | 161 ++++++++++++++++
 tb/tb_alu_req_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer
// Shares a single 8-bit ALU between two requesters. A request is granted in IDLE,
// its operands are held on the ALU inputs for ALU_LAT cycles, and the ALU result
// is captured and presented on one tagged valid/ready response channel.
// The block performs no arithmetic; it only steers and captures.
module alu_req_sequencer #(
    parameter int ALU_LAT = 1,  // legal range 1..15 (fits the 4-bit latency counter)
    parameter int RR_EN   = 1   // 1 = round-robin, 0 = fixed priority to requester 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_sel,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_f,
    output logic       rsp_ovf,
    output logic       rsp_branch,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_f,
    input  logic       alu_ovf,
    input  logic       alu_take_branch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    state_t     state_q, state_d;
    // rr_ptr holds the requester preferred on the next tie. Reset value 0 favours
    // requester 0; after each grant it points at the requester that was not granted,
    // which is the same as "not the last granted".
    logic       rr_ptr_q, rr_ptr_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [2:0] sel_q, sel_d;
    logic       id_q, id_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] f_q, f_d;
    logic       ovf_q, ovf_d;
    logic       br_q, br_d;

    logic       grant_vld;
    logic       grant_id;

    // Arbitration: pick a requester from the current valids; ready only offered in IDLE.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = (RR_EN != 0) ? rr_ptr_q : 1'b0;
        end else begin
            grant_id = !req0_valid;
        end
        req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
        req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;
    end

    // Next-state logic: accept, hold operands for ALU_LAT cycles, capture, hand off.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        f_d         = f_q;
        ovf_d       = ovf_q;
        br_d        = br_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    a_d      = grant_id ? req1_a   : req0_a;
                    b_d      = grant_id ? req1_b   : req0_b;
                    sel_d    = grant_id ? req1_sel : req0_sel;
                    id_d     = grant_id;
                    rr_ptr_d = ~grant_id;
                    cnt_d    = LAT_M1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    f_d         = alu_f;
                    ovf_d       = alu_ovf;
                    br_d        = alu_take_branch;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            a_q         <= 8'd0;
            b_q         <= 8'd0;
            sel_q       <= 3'd0;
            id_q        <= 1'b0;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            f_q         <= 8'd0;
            ovf_q       <= 1'b0;
            br_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            f_q         <= f_d;
            ovf_q       <= ovf_d;
            br_q        <= br_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_sel    = sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_f      = f_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_branch = br_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer. Three instances share the request inputs:
// inst 0 = ALU_LAT 1 round-robin, inst 1 = ALU_LAT 1 fixed priority,
// inst 2 = ALU_LAT 3 round-robin. Each instance drives its own small ALU model.
module tb_alu_req_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid, rsp_ready;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;

    logic       r0_rdy [3];
    logic       r1_rdy [3];
    logic       rsp_valid [3];
    logic       rsp_id [3];
    logic [7:0] rsp_f [3];
    logic       rsp_ovf [3];
    logic       rsp_branch [3];
    logic [7:0] alu_a [3];
    logic [7:0] alu_b [3];
    logic [2:0] alu_sel [3];
    logic [7:0] alu_f [3];
    logic       alu_ovf [3];
    logic       alu_br [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 asr, 101 xor,
    // 110 sub with branch on equal, 111 not. Returns {ovf, branch, f}.
    function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] sel);
        logic [7:0] f;
        logic       ovf;
        logic       br;
        f = 8'd0; ovf = 1'b0; br = 1'b0;
        case (sel)
            3'd0: begin f = a + b; ovf = (a[7] == b[7]) && (f[7] != a[7]); end
            3'd1: begin f = a - b; ovf = (a[7] != b[7]) && (f[7] != a[7]); end
            3'd2: f = a & b;
            3'd3: f = a | b;
            3'd4: f = {a[7], a[7:1]};
            3'd5: f = a ^ b;
            3'd6: begin f = a - b; br = (a == b); end
            default: f = ~a;
        endcase
        return {ovf, br, f};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_req_sequencer #(
            .ALU_LAT(g == 2 ? 3 : 1),
            .RR_EN  (g == 1 ? 0 : 1)
        ) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .req0_valid     (req0_valid),
            .req0_ready     (r0_rdy[g]),
            .req0_a         (req0_a),
            .req0_b         (req0_b),
            .req0_sel       (req0_sel),
            .req1_valid     (req1_valid),
            .req1_ready     (r1_rdy[g]),
            .req1_a         (req1_a),
            .req1_b         (req1_b),
            .req1_sel       (req1_sel),
            .rsp_valid      (rsp_valid[g]),
            .rsp_ready      (rsp_ready),
            .rsp_id         (rsp_id[g]),
            .rsp_f          (rsp_f[g]),
            .rsp_ovf        (rsp_ovf[g]),
            .rsp_branch     (rsp_branch[g]),
            .alu_a          (alu_a[g]),
            .alu_b          (alu_b[g]),
            .alu_sel        (alu_sel[g]),
            .alu_f          (alu_f[g]),
            .alu_ovf        (alu_ovf[g]),
            .alu_take_branch(alu_br[g])
        );
        assign {alu_ovf[g], alu_br[g], alu_f[g]} = alu_model(alu_a[g], alu_b[g], alu_sel[g]);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = 8'd0; req0_b = 8'd0; req0_sel = 3'd0;
        req1_a = 8'd0; req1_b = 8'd0; req1_sel = 3'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int q_rr[$];
        int q_fp[$];
        int both;
        int seen;

        // Reset state
        do_reset();
        #1;
        chk("rst_rsp_valid", rsp_valid[0], 0);
        chk("rst_alu_a", alu_a[0], 0);
        chk("rst_ready0", r0_rdy[0], 0);
        chk("rst_rsp_f", rsp_f[0], 0);

        // Reset in the middle of EXEC discards the op
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h33; req0_b = 8'h11; req0_sel = 3'd0;
        #1 chk("t1_accept", r0_rdy[0], 1);
        @(negedge clk);
        req0_valid = 1'b0;
        #1 chk("t1_exec_alu_a", alu_a[0], 8'h33);
        rst_n = 1'b0;
        #1;
        chk("t1_alu_a_zero", alu_a[0], 0);
        chk("t1_alu_sel_zero", alu_sel[0], 0);
        chk("t1_rsp_valid_zero", rsp_valid[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (rsp_valid[0]) seen = 1;
        end
        chk("t1_no_rsp_after_reset", seen, 0);

        // Single op, ALU_LAT 1: 0x70 + 0x20
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h70; req0_b = 8'h20; req0_sel = 3'b000;
        #1;
        chk("t2_ready0", r0_rdy[0], 1);
        chk("t2_ready1", r1_rdy[0], 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk("t2_alu_a", alu_a[0], 8'h70);
        chk("t2_alu_b", alu_b[0], 8'h20);
        chk("t2_rsp_not_yet", rsp_valid[0], 0);
        @(negedge clk); #1;
        chk("t2_rsp_valid", rsp_valid[0], 1);
        chk("t2_rsp_f", rsp_f[0], 8'h90);
        chk("t2_rsp_ovf", rsp_ovf[0], 1);
        chk("t2_rsp_id", rsp_id[0], 0);
        chk("t2_alu_hold", alu_a[0], 8'h70);
        @(negedge clk); #1;
        chk("t2_rsp_drop", rsp_valid[0], 0);

        // Both valid continuously: round-robin vs fixed priority
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_sel = 3'd3;
        req1_valid = 1'b1; req1_a = 8'h04; req1_b = 8'h08; req1_sel = 3'd3;
        both = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (r0_rdy[0] || r1_rdy[0]) q_rr.push_back(int'(r1_rdy[0]));
            if (r0_rdy[1] || r1_rdy[1]) q_fp.push_back(int'(r1_rdy[1]));
            if ((r0_rdy[0] && r1_rdy[0]) || (r0_rdy[1] && r1_rdy[1])) both = 1;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_never_both", both, 0);
        chk("t3_rr_count", q_rr.size() >= 4, 1);
        chk("t3_fp_count", q_fp.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_rr_grant%0d", i), (i < q_rr.size()) ? q_rr[i] : 9, i % 2);
            chk($sformatf("t3_fp_grant%0d", i), (i < q_fp.size()) ? q_fp[i] : 9, 0);
        end

        // Backpressure: response held 5 cycles, no new grant
        do_reset();
        rsp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'h03; req0_b = 8'h04; req0_sel = 3'd0;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1;
        req1_a = 8'h10; req1_b = 8'h01; req1_sel = 3'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("t4_valid%0d", c), rsp_valid[0], 1);
            chk($sformatf("t4_f%0d", c), rsp_f[0], 8'h07);
            chk($sformatf("t4_id%0d", c), rsp_id[0], 0);
            chk($sformatf("t4_rdy1_%0d", c), r1_rdy[0], 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk("t4_released", rsp_valid[0], 0);
        chk("t4_idle_grant1", r1_rdy[0], 1);
        req1_valid = 1'b0;

        // ALU_LAT 3: operands held 3 cycles, branch captured
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h05; req1_sel = 3'b110;
        #1 chk("t5_ready1", r1_rdy[2], 1);
        @(negedge clk);
        req1_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("t5_alu_a%0d", c), alu_a[2], 8'h05);
            chk($sformatf("t5_alu_sel%0d", c), alu_sel[2], 3'b110);
            chk($sformatf("t5_no_rsp%0d", c), rsp_valid[2], 0);
            @(negedge clk);
        end
        #1;
        chk("t5_rsp_valid", rsp_valid[2], 1);
        chk("t5_rsp_branch", rsp_branch[2], 1);
        chk("t5_rsp_f", rsp_f[2], 8'h00);
        chk("t5_rsp_id", rsp_id[2], 1);

        // Arithmetic shift passed through: 0xF0 >>> 1
        do_reset();
        rsp_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h00; req0_sel = 3'b100;
        @(negedge clk);
        req0_valid = 1'b0;
        #1 chk("t6_alu_sel", alu_sel[0], 3'b100);
        @(negedge clk); #1;
        chk("t6_rsp_valid", rsp_valid[0], 1);
        chk("t6_rsp_f", rsp_f[0], 8'hF8);
        chk("t6_rsp_ovf", rsp_ovf[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
